kernel_ram_ctrl: RTL
====================

# kernel_ram_ctrl

Initiator-side controller for the 8-word × 8-bit synchronous kernel RAM (`RAM_word8_bit8`) in the 2D convolution processor. In LOAD, it accepts a burst of WORDS kernel bytes over a valid/ready stream and writes them to RAM addresses 0..WORDS-1. In READ, it replays the stored words in address order for a programmable number of passes, absorbing the RAM's one-cycle registered read latency. Its output is a valid/last stream that feeds the MAC datapath.

## Interface
Parameters:
- `WORDS`, 8, number of RAM words; must equal the RAM depth.
- `AW`, 3, RAM address width; 2^AW ≥ WORDS.
- `DW`, 8, data width.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load_start` in 1: request a LOAD burst; sampled in IDLE only.
- `read_start` in 1: request a READ sequence; sampled in IDLE only.
- `passes` in 4: number of full read passes; sampled with `read_start`; 0 is treated as 1.
- `in_valid` in 1: write-stream data valid.
- `in_data` in DW: write-stream byte.
- `in_ready` out 1: controller accepts a beat; high only in LOAD.
- `out_valid` out 1: `out_data` holds a RAM word.
- `out_data` out DW: replayed word; 0 when `out_valid` = 0.
- `out_last` out 1: final word of the final pass.
- `busy` out 1: state ≠ IDLE.
- `loaded` out 1: a complete WORDS-beat burst has been written since reset.
- `ram_wr` out 1: to RAM `wr`; 1 = write, 0 = read.
- `ram_addr` out AW: to RAM `address`.
- `ram_din` out DW: to RAM `din`.
- `ram_dout` in DW: from RAM `dout`, registered inside the RAM.

## Operation
- States: IDLE, LOAD, READ, DRAIN.
- **IDLE**
  - `ram_wr` = 0, `ram_addr` = 0, `ram_din` = 0, `in_ready` = 0.
  - `load_start` → LOAD; clear `wptr` and `loaded`.
  - Otherwise, `read_start` with `loaded` = 1 → READ; clear `rptr`; latch `passes` (0→1) into `pass_left`.
  - `read_start` with `loaded` = 0 is ignored. If both starts are high, `load_start` wins.
- **LOAD**
  - `in_ready` = 1.
  - `ram_wr` = `in_valid`, `ram_addr` = `wptr`, `ram_din` = `in_data`, all combinational, so the RAM captures the beat on the same edge.
  - On each accepted beat, `wptr`++.
  - The beat with `wptr` = WORDS-1 sets `loaded` = 1 and moves to IDLE.
  - With `in_valid` low, `ram_wr` = 0 and no write occurs.
  - `load_start` and `read_start` are ignored.
- **READ**
  - Each cycle: `ram_wr` = 0, `ram_addr` = `rptr`; a registered `issue` flag is set to 1.
  - `rptr` wraps from WORDS-1 to 0 and decrements `pass_left`.
  - Issuing address WORDS-1 with `pass_left` = 1 sets a registered `issue_last` flag and moves to DRAIN.
- **DRAIN**
  - One cycle; `ram_wr` = 0, `ram_addr` = 0; then IDLE.
- **Output stream**
  - `out_valid` = `issue` (registered one cycle after its address).
  - `out_data` = `out_valid` ? `ram_dout` : 0.
  - `out_last` = `issue_last`.
  - There is no backpressure; the consumer must accept every beat.
- **Reset**
  - Asserting `rst_n` at any time, including mid-LOAD or mid-READ, forces IDLE and clears `wptr`, `rptr`, `pass_left`, `issue`, `issue_last`, and `loaded`.
  - RAM contents are not cleared, but are considered invalid until a new LOAD completes.
- **Reset values of outputs:** `in_ready`, `out_valid`, `out_data`, `out_last`, `busy`, `loaded`, `ram_wr`, `ram_addr`, `ram_din` are all 0.

## Timing
- **Start:** `load_start`/`read_start` sampled at edge N puts the controller in LOAD/READ during cycle N+1.
- **LOAD throughput:** one beat per cycle. A gapless burst occupies exactly WORDS cycles; `loaded` rises on the edge that captures the last beat.
- **READ latency:**
  - Address k is issued in cycle t; the word appears on `out_valid`/`out_data` in cycle t+1.
  - A P-pass read produces P·WORDS consecutive valid beats with no gaps, including across pass wrap.
- **`busy`:**
  - READ: high for P·WORDS+1 cycles (READ plus DRAIN).
  - LOAD: high for WORDS cycles plus any idle gaps.
- **Back-to-back:** the earliest next start is sampled in the first IDLE cycle after DRAIN.

## Test plan
- **Reset state:** after reset, all outputs are 0; `read_start`=1 with `loaded`=0 → stays IDLE, no `out_valid`.
- **Gapless load:** load bytes 0x11..0x88 with no gaps → RAM addresses 0..7 hold 0x11..0x88; `loaded`=1 after 8 cycles; `in_ready` falls next cycle.
- **Gappy load:** load with `in_valid` deasserted on alternate cycles → `ram_wr` pulses only on valid beats; contents match.
- **Multi-pass read:** `read_start`, `passes`=2 → 16 consecutive beats 0x11..0x88, 0x11..0x88, first beat 2 cycles after the start edge; `out_last` only on the 16th; `busy` high 17 cycles.
- **Boundary starts:** `passes`=0 behaves as 1 (8 beats); `load_start` and `read_start` together → LOAD taken.
- **Reset mid-read:** `rst_n` low during the 5th beat of a read → `out_valid`=0 immediately and `loaded`=0; a subsequent `read_start` is ignored until a reload.

Source files
------------

// File: rtl/kernel_ram_ctrl.sv
// Kernel RAM controller: loads a burst of kernel bytes into the 8x8 kernel RAM
// and replays them in address order for a programmable number of passes,
// hiding the RAM's one-cycle registered read latency behind an issue flag.
module kernel_ram_ctrl #(
  parameter int WORDS = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start_i,
  input  logic          read_start_i,
  input  logic [3:0]    passes_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          busy_o,
  output logic          loaded_o,
  output logic          ram_wr_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [AW-1:0] LastAddr = AW'(WORDS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [3:0]    passLeft_q, passLeft_d;
  logic          issue_q, issue_d;
  logic          issueLast_q, issueLast_d;
  logic          loaded_q, loaded_d;

  // State and datapath registers; reset returns to IDLE and invalidates the RAM image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      passLeft_q  <= '0;
      issue_q     <= 1'b0;
      issueLast_q <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      passLeft_q  <= passLeft_d;
      issue_q     <= issue_d;
      issueLast_q <= issueLast_d;
      loaded_q    <= loaded_d;
    end
  end

  // Next-state logic and RAM-side drive; LOAD writes pass straight through so the beat lands on the accepting edge.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    passLeft_d  = passLeft_q;
    issue_d     = 1'b0;
    issueLast_d = 1'b0;
    loaded_d    = loaded_q;
    in_ready_o  = 1'b0;
    ram_wr_o    = 1'b0;
    ram_addr_o  = '0;
    ram_din_o   = '0;

    unique case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d  = LOAD;
          wptr_d   = '0;
          loaded_d = 1'b0;
        end else if (read_start_i && loaded_q) begin
          state_d    = READ;
          rptr_d     = '0;
          passLeft_d = (passes_i == 4'd0) ? 4'd1 : passes_i;
        end
      end

      LOAD: begin
        in_ready_o = 1'b1;
        ram_wr_o   = in_valid_i;
        ram_addr_o = wptr_q;
        ram_din_o  = in_data_i;
        if (in_valid_i) begin
          wptr_d = wptr_q + AW'(1);
          if (wptr_q == LastAddr) begin
            loaded_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      READ: begin
        ram_addr_o = rptr_q;
        issue_d    = 1'b1;
        if (rptr_q == LastAddr) begin
          rptr_d     = '0;
          passLeft_d = passLeft_q - 4'd1;
          if (passLeft_q == 4'd1) begin
            issueLast_d = 1'b1;
            state_d     = DRAIN;
          end
        end else begin
          rptr_d = rptr_q + AW'(1);
        end
      end

      DRAIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid_o = issue_q;
  assign out_data_o  = issue_q ? ram_dout_i : '0;
  assign out_last_o  = issueLast_q;
  assign busy_o      = (state_q != IDLE);
  assign loaded_o    = loaded_q;

endmodule
